// File: rtl/cordic_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_mul_arbiter_if
// Description : Requester/response bus for the shared CORDIC multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_x;
    logic [NUM_REQ*DW-1:0] req_z;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DW-1:0]       rsp_y;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_timeout;

    modport master (
        output req_valid, req_x, req_z, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_timeout
    );

    modport slave (
        input  req_valid, req_x, req_z, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, rsp_timeout
    );
endinterface
`default_nettype wire

// File: rtl/cordic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_mul_arbiter
// Description : Round-robin sharing of one start/done multiplier with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire                 clk,
    input  wire                 rst,
    cordic_mul_arbiter_if.slave bus,
    output logic                mul_start,
    output logic [DW-1:0]       mul_x,
    output logic [DW-1:0]       mul_z,
    input  wire  [2*DW-1:0]     mul_y,
    input  wire                 mul_done,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [ID_W-1:0] r_rr;
    logic [ID_W-1:0] r_id;
    logic [DW-1:0]   r_x;
    logic [DW-1:0]   r_z;
    logic [2*DW-1:0] r_y;
    logic            r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_rr_next;
    logic            w_found;
    logic            w_any;
    logic            w_accept;
    logic            w_cnt_hit;

    // Search from the round-robin pointer; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_any     = |bus.req_valid;
    assign w_accept  = (r_state == S_IDLE) && w_any;
    assign w_cnt_hit = (r_cnt == C_CNT_LAST);
    assign w_rr_next = ID_W'((int'(w_grant) + 1) % NUM_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE:   if (mul_done || w_cnt_hit) w_next_state = S_RELEASE;
            // A done level left over from this op must clear before responding.
            S_RELEASE: if (!mul_done) w_next_state = S_RESP;
            S_RESP:    if (bus.rsp_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_accept) begin
            bus.req_ready[w_grant] = 1'b1;
        end
        bus.rsp_valid = (r_state == S_RESP);
        mul_start     = (r_state == S_ISSUE);
        busy          = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr      <= '0;
            r_id      <= '0;
            r_x       <= '0;
            r_z       <= '0;
            r_y       <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= bus.req_x[w_grant*DW +: DW];
                r_z   <= bus.req_z[w_grant*DW +: DW];
                r_id  <= w_grant;
                r_rr  <= w_rr_next;
                r_cnt <= '0;
            end
            // Done on the watchdog's final cycle still counts as success.
            if (r_state == S_ISSUE) begin
                if (mul_done) begin
                    r_y       <= mul_y;
                    r_timeout <= 1'b0;
                end else if (w_cnt_hit) begin
                    r_y       <= '0;
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign mul_x           = r_x;
    assign mul_z           = r_z;
    assign bus.rsp_y       = r_y;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cordic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_mul_arbiter
// Description : Self-checking bench with a start/done multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mul_start;
    logic [DW-1:0]   mul_x;
    logic [DW-1:0]   mul_z;
    logic [2*DW-1:0] mul_y    = '0;
    logic            mul_done = 1'b0;
    logic            busy;

    cordic_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .ID_W(ID_W)) ifc ();

    cordic_mul_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_z     (mul_z),
        .mul_y     (mul_y),
        .mul_done  (mul_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return 16'(ia * ib);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Multiplier model: done after m_lat start cycles, held m_hold cycles after start drops.
    int m_lat = 4;
    int m_hold = 0;
    bit m_never = 1'b0;
    int m_cnt = 0;
    int m_hcnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt    <= 0;
            m_hcnt   <= 0;
            mul_done <= 1'b0;
            mul_y    <= '0;
        end else if (mul_start) begin
            m_cnt  <= m_cnt + 1;
            m_hcnt <= m_hold;
            if (!m_never && (m_cnt + 1 == m_lat - 1)) begin
                mul_done <= 1'b1;
                mul_y    <= prod(mul_x, mul_z);
            end
        end else begin
            m_cnt <= 0;
            if (mul_done) begin
                if (m_hcnt <= 1) mul_done <= 1'b0;
                else m_hcnt <= m_hcnt - 1;
            end
        end
    end

    // Reference model: round-robin grant rule plus FIFO of expected responses.
    typedef struct { int id; logic [15:0] y; bit to; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   exp_rr = 0;
    int   grant_log[$];
    int   rsp_cnt = 0;
    int   viol_onehot = 0;
    int   viol_early = 0;
    bit   prev_start = 1'b0;
    int   mg;
    int   meg;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_rr     = 0;
            prev_start = 1'b0;
        end else begin
            if ($countones(ifc.req_ready) > 1) viol_onehot++;
            if (mul_start && !prev_start && mul_done) viol_early++;
            prev_start = mul_start;
            if ((ifc.req_ready & ifc.req_valid) != '0) begin
                mg = -1;
                for (int i = 0; i < NUM_REQ; i++)
                    if (mg < 0 && ifc.req_ready[i]) mg = i;
                meg = -1;
                for (int k = 0; k < NUM_REQ; k++)
                    if (meg < 0 && ifc.req_valid[(exp_rr + k) % NUM_REQ]) meg = (exp_rr + k) % NUM_REQ;
                check("grant", mg, meg);
                mon_e.id = mg;
                mon_e.to = m_never;
                mon_e.y  = m_never ? 16'h0 : prod(ifc.req_x[mg*DW +: DW], ifc.req_z[mg*DW +: DW]);
                exp_q.push_back(mon_e);
                grant_log.push_back(mg);
                exp_rr = (mg + 1) % NUM_REQ;
            end
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got id %0d y %0h with no outstanding op", ifc.rsp_id, ifc.rsp_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_id", ifc.rsp_id, mon_e.id);
                    check("rsp_y", ifc.rsp_y, mon_e.y);
                    check("rsp_timeout", ifc.rsp_timeout, mon_e.to);
                end
            end
        end
    end

    typedef struct {
        int id; logic [7:0] x; logic [7:0] z; int lat; bit never; logic [15:0] exp_y; bit exp_to;
    } vec_t;
    vec_t vecs[7];

    task automatic wait_rsp(output bit ok, output int sc);
        ok = 1'b0;
        sc = 0;
        for (int c = 0; c < 400; c++) begin
            if (ifc.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            if (mul_start) sc++;
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait_timeout: got no rsp_valid, required one within 400 cycles");
        end
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 400 && busy; c++) @(negedge clk);
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int sc;
        m_lat   = v.lat;
        m_never = v.never;
        m_hold  = 0;
        @(negedge clk);
        ifc.req_x = $urandom;
        ifc.req_z = $urandom;
        ifc.req_x[v.id*DW +: DW] = v.x;
        ifc.req_z[v.id*DW +: DW] = v.z;
        ifc.req_valid = NUM_REQ'(1) << v.id;
        #1;
        check("vec_ready", ifc.req_ready, NUM_REQ'(1) << v.id);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = '0;
        wait_rsp(ok, sc);
        if (ok) begin
            check("vec_y", ifc.rsp_y, v.exp_y);
            check("vec_id", ifc.rsp_id, v.id);
            check("vec_timeout", ifc.rsp_timeout, v.exp_to);
            check("vec_start_cycles", sc, v.never ? TIMEOUT : v.lat);
        end
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        check("vec_idle_after", busy, 1'b0);
        m_never = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        bit          ok;
        int          sc;
        int          base;
        int          rel;
        int          err_stable;
        int          err_ready;
        int          no_rsp;
        logic [3:0]  pend;
        logic [15:0] cap_y;
        logic [1:0]  cap_id;
        logic        cap_to;

        vecs[0] = '{2, 8'd12, 8'hFB, 8,  1'b0, 16'hFFC4, 1'b0};
        vecs[1] = '{0, 8'h80, 8'h80, 3,  1'b0, 16'h4000, 1'b0};
        vecs[2] = '{3, 8'h7F, 8'h80, 2,  1'b0, 16'hC080, 1'b0};
        vecs[3] = '{1, 8'd7,  8'd9,  5,  1'b1, 16'h0000, 1'b1};
        vecs[4] = '{1, 8'd0,  8'hB3, 4,  1'b0, 16'h0000, 1'b0};
        vecs[5] = '{3, 8'hFF, 8'hFF, 2,  1'b0, 16'h0001, 1'b0};
        vecs[6] = '{0, 8'd3,  8'd4,  64, 1'b0, 16'd12,   1'b0};

        ifc.req_valid = '0;
        ifc.req_x     = '0;
        ifc.req_z     = '0;
        ifc.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check("rst_mul_start", mul_start, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Done held high after start drops: next issue must wait for it.
        m_lat = 3; m_hold = 5; m_never = 1'b0;
        base = rsp_cnt; rel = 0; pend = '0;
        @(negedge clk);
        ifc.req_x = $urandom;
        ifc.req_z = $urandom;
        ifc.req_x[7:0] = 8'd10;  ifc.req_z[7:0]  = 8'd11;
        ifc.req_x[15:8] = 8'hFD; ifc.req_z[15:8] = 8'd20;
        ifc.req_valid = 4'b0011;
        ifc.rsp_ready = 1'b1;
        for (int c = 0; c < 300 && rsp_cnt < base + 2; c++) begin
            @(negedge clk);
            ifc.req_valid = ifc.req_valid & ~pend;
            if (busy && !mul_start && !ifc.rsp_valid) rel++;
            pend = ifc.req_ready & ifc.req_valid;
        end
        check("hold_rsp_count", rsp_cnt - base, 2);
        tests++;
        if (rel < 2 * m_hold) begin
            fails++;
            $display("FAIL hold_release_len: got %0d release cycles, required at least %0d", rel, 2 * m_hold);
        end
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b0;
        m_hold = 0;
        wait_idle();

        // Fairness from reset with everyone requesting.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        m_lat = 3;
        base = rsp_cnt;
        ifc.req_x = {4{8'd127}};
        ifc.req_z = {4{8'd127}};
        ifc.req_valid = 4'hF;
        ifc.rsp_ready = 1'b1;
        for (int c = 0; c < 300 && rsp_cnt < base + 5; c++) begin
            @(negedge clk);
            if (ifc.rsp_valid) check("fair_y", ifc.rsp_y, 16'd16129);
        end
        check("fair_rsp_count", rsp_cnt - base, 5);
        for (int i = 0; i < 5; i++)
            check("fair_order", (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);
        ifc.req_valid = '0;
        wait_idle();
        ifc.rsp_ready = 1'b0;

        // Response back-pressure with another requester waiting.
        m_lat = 3;
        @(negedge clk);
        ifc.req_x[7:0] = 8'd33; ifc.req_z[7:0] = 8'hFE;
        ifc.req_x[15:8] = 8'd5; ifc.req_z[15:8] = 8'd6;
        ifc.req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = '0;
        wait_rsp(ok, sc);
        cap_y = ifc.rsp_y; cap_id = ifc.rsp_id; cap_to = ifc.rsp_timeout;
        check("bp_y", cap_y, 16'hFFBE);
        ifc.req_valid = 4'b0010;
        err_stable = 0; err_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!ifc.rsp_valid || ifc.rsp_y !== cap_y || ifc.rsp_id !== cap_id || ifc.rsp_timeout !== cap_to)
                err_stable++;
            if (ifc.req_ready != '0) err_ready++;
        end
        check("bp_stable", err_stable, 0);
        check("bp_ready_zero", err_ready, 0);
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        check("bp_grant1", ifc.req_ready, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = '0;
        wait_rsp(ok, sc);
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;

        // Reset pulse in the middle of ISSUE.
        m_lat = 30;
        ifc.req_x[15:8] = 8'd9; ifc.req_z[15:8] = 8'd9;
        ifc.req_valid = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = '0;
        repeat (5) @(negedge clk);
        check("pre_rst_issue", mul_start, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req_ready", ifc.req_ready, 4'b0000);
        check("mid_rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check("mid_rst_rsp_y", ifc.rsp_y, 16'h0);
        check("mid_rst_rsp_id", ifc.rsp_id, 2'd0);
        check("mid_rst_rsp_timeout", ifc.rsp_timeout, 1'b0);
        check("mid_rst_mul_start", mul_start, 1'b0);
        check("mid_rst_mul_x", mul_x, 8'h0);
        check("mid_rst_mul_z", mul_z, 8'h0);
        check("mid_rst_busy", busy, 1'b0);
        no_rsp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifc.rsp_valid || busy) no_rsp++;
        end
        check("mid_rst_no_rsp", no_rsp, 0);
        m_lat = 3;
        ifc.req_valid = 4'b0101;
        #1;
        check("mid_rst_rr_zero", ifc.req_ready, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = '0;
        wait_rsp(ok, sc);
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!busy && (c % 40 == 0)) begin
                m_lat  = $urandom_range(2, 6);
                m_hold = $urandom_range(0, 3);
            end
            ifc.req_valid = 4'($urandom);
            ifc.req_x     = $urandom;
            ifc.req_z     = $urandom;
            ifc.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("onehot_ready", viol_onehot, 0);
        check("no_early_start", viol_early, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required finish within 50000 cycles");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/cordic_mul_arbiter.md
Name: cordic_mul_arbiter

Overview:
- Shares one approximate CORDIC multiplier (start/done handshake, signed 8-bit x/z, 16-bit y) among NUM_REQ requesters.
- Round-robin grant; operands and tag are registered and issued to the multiplier.
- The multiplier handshake is sequenced as start-hold-until-done, then release. The result is returned on one shared response channel with the requester id.
- A watchdog aborts hung operations and reports a timeout instead of hanging the fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, signed operand width; result width is 2*DW.
- TIMEOUT, 64, max cycles mul_start may stay high without mul_done (>=4).
- ID_W, $clog2(NUM_REQ), requester tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  NUM_REQ*DW  packed signed operands x; slice i belongs to requester i.
- req_z  in  NUM_REQ*DW  packed signed operands z.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_y  out  2*DW  signed product (0 on timeout).
- rsp_id  out  ID_W  index of the requester that owns rsp_y.
- rsp_timeout  out  1  high with rsp_valid when the operation was aborted.
- mul_start  out  1  to multiplier start.
- mul_x  out  DW  to multiplier x.
- mul_z  out  DW  to multiplier z.
- mul_y  in  2*DW  from multiplier y.
- mul_done  in  1  from multiplier done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - State goes to IDLE; rr pointer goes to 0.
  - All outputs go to 0: req_ready, rsp_valid, rsp_y, rsp_id, rsp_timeout, mul_start, mul_x, mul_z, busy.
  - Reset mid-operation abandons the operation with no response; mul_start drops on the next cycle.
- FSM states: IDLE, ISSUE, RELEASE, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i], searching rr, rr+1, ... modulo NUM_REQ.
  - req_ready[g] is driven combinationally high only in IDLE and only when some req_valid is set.
  - On req_valid[g] & req_ready[g], register mul_x = req_x slice g, mul_z = req_z slice g, id = g, rr = (g+1) mod NUM_REQ, then go to ISSUE.
  - mul_start rises the cycle after acceptance.
- ISSUE:
  - mul_start = 1; mul_x and mul_z are held stable; the watchdog counter increments each cycle.
  - mul_done sampled high: capture y = mul_y, timeout = 0, then go to RELEASE.
  - Counter reaches TIMEOUT with no done: y = 0, timeout = 1, then go to RELEASE.
- RELEASE:
  - mul_start = 0.
  - Wait until mul_done is sampled low, then go to RESP.
  - If mul_done is already low, stay exactly one cycle.
  - Purpose: a level-held done from the previous op must never complete the next op.
- RESP:
  - rsp_valid = 1; rsp_y, rsp_id and rsp_timeout are stable while valid.
  - On rsp_valid & rsp_ready, go to IDLE.
  - Back-pressure holds indefinitely; no new request is accepted while in RESP.
- Minimum issue latency: accept at edge T, mul_start high at T+1. If the multiplier takes L cycles to done, rsp_valid is high at T+L+3.
- Simultaneous events:
  - mul_done arriving on the same cycle the counter hits TIMEOUT counts as success.
  - A requester dropping req_valid while not granted is legal.
  - A granted requester that has not handshaken may drop valid; arbitration re-evaluates next cycle.
- Fairness: with all NUM_REQ requesting continuously, grants cycle 0,1,2,3,0,...; each requester waits at most NUM_REQ-1 operations.
- mul_y is captured unmodified, as a signed 2*DW value; no rounding or error correction is applied.

Test Plan:
- Single request from requester 2 with x=12, z=-5, and a model multiplier that asserts done after 8 cycles.
  -> rsp_valid, rsp_y=16'hFFC4 (-60), rsp_id=2, rsp_timeout=0.
  -> mul_start high exactly 8 cycles.
- All 4 requesters valid continuously, each with x=127, z=127, rsp_ready=1.
  -> grant order 0,1,2,3,0.
  -> every rsp_y=16129.
  -> never two req_ready bits high.
- Model holds done high for 5 cycles after start drops.
  -> RELEASE lasts 5 cycles; the next mul_start does not rise until done is low.
  -> the second result is not corrupted.
- Model never asserts done, with TIMEOUT=64.
  -> mul_start drops after 64 cycles.
  -> response has rsp_timeout=1, rsp_y=0, correct rsp_id.
- rsp_ready held low 20 cycles, with requester 1 valid in the meantime.
  -> rsp fields stay stable.
  -> req_ready stays all-zero until the response handshake, then requester 1 is granted.
- rst pulsed for one cycle while in ISSUE.
  -> next cycle: all outputs are 0, state is IDLE, rr=0, and no response is emitted.
